// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: answers mem_ctrl_op requests with one single-byte
// transaction on a 23LC512-style SPI SRAM (mode 0, SCLK = clock/2).
package controlpack;
  typedef enum logic [1:0] {
    MEM_NOP   = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_ctrl_op_e;
endpackage

module spi_mem_ctrl
  import controlpack::*;
#(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDR_WIDTH     = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                mem_ctrl_op,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_BUS_WIDTH-1:0] data_in,
  output logic [DATA_BUS_WIDTH-1:0] data_out,
  output logic                      mem_op_done,
  output logic                      spi_cs_n,
  output logic                      spi_sclk,
  output logic                      spi_mosi,
  input  logic                      spi_miso
);

  localparam int FW = 24 + DATA_BUS_WIDTH;
  localparam int CW = $clog2(FW);
  localparam logic [CW-1:0] LAST = CW'(FW - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE,
    GAP
  } state_e;

  state_e                    state_q, state_d;
  logic [FW-1:0]             sr_q, sr_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      phase_q, phase_d;
  logic                      rd_q, rd_d;
  logic [DATA_BUS_WIDTH-1:0] dout_q, dout_d;
  logic                      cs_n_q, cs_n_d;
  logic                      sclk_q, sclk_d;
  logic                      mosi_q, mosi_d;
  logic                      done_q, done_d;
  logic                      is_rd, is_wr;
  logic [7:0]                cmd;
  logic [DATA_BUS_WIDTH-1:0] payload;

  // Next-state and next-output logic; pins are registered below.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    rd_d    = rd_q;
    dout_d  = dout_q;
    cs_n_d  = 1'b1;
    sclk_d  = 1'b0;
    mosi_d  = 1'b0;
    done_d  = 1'b0;
    is_rd   = (mem_ctrl_op == MEM_READ);
    is_wr   = (mem_ctrl_op == MEM_WRITE);
    cmd     = is_rd ? 8'h03 : 8'h02;
    payload = is_rd ? '0 : data_in;
    unique case (state_q)
      IDLE: begin
        if (is_rd || is_wr) begin
          rd_d    = is_rd;
          sr_d    = {cmd, 16'(address), payload};
          cnt_d   = '0;
          phase_d = 1'b0;
          state_d = SHIFT;
          cs_n_d  = 1'b0;
          mosi_d  = sr_d[FW-1];
        end
      end
      SHIFT: begin
        cs_n_d = 1'b0;
        if (!phase_q) begin
          // Rising SCLK half: MOSI holds the current MSB.
          phase_d = 1'b1;
          sclk_d  = 1'b1;
          mosi_d  = sr_q[FW-1];
        end else begin
          // Falling SCLK half: capture MISO, present next bit.
          sr_d    = {sr_q[FW-2:0], spi_miso};
          phase_d = 1'b0;
          if (cnt_q == LAST) begin
            state_d = DONE;
            cs_n_d  = 1'b1;
            done_d  = 1'b1;
            if (rd_q) begin
              dout_d = sr_d[DATA_BUS_WIDTH-1:0];
            end
          end else begin
            cnt_d  = cnt_q + CW'(1);
            mosi_d = sr_d[FW-1];
          end
        end
      end
      DONE: begin
        state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and pin registers with async reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      rd_q    <= 1'b0;
      dout_q  <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      rd_q    <= rd_d;
      dout_q  <= dout_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  assign data_out    = dout_q;
  assign mem_op_done = done_q;
  assign spi_cs_n    = cs_n_q;
  assign spi_sclk    = sclk_q;
  assign spi_mosi    = mosi_q;

endmodule
